// File: rtl/didactic_reset_ctrl.sv
// Reset sequencer for the Didactic SoC: synchronises PLL lock and the board button, debounces the
// button and releases a stretched, synchronous active-low core reset. Optional cause register: RESET_CAUSE_EN.
module didactic_reset_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 80000,
  parameter int HOLD_CYCLES     = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       btn_reset,
`ifdef RESET_CAUSE_EN
  input  logic       cause_clr,
  output logic [1:0] cause,
`endif
  output logic       soc_reset_n,
  output logic       lock_sync,
  output logic       btn_stable
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RUN       = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] lock_ff;
  logic [SYNC_STAGES-1:0] btn_ff;
  logic                   btn_sync;
  logic [DW-1:0]          db_cnt;
  logic [HW-1:0]          hold_cnt;
  state_t                 state;
  logic                   release_ok;

  assign lock_sync  = lock_ff[SYNC_STAGES-1];
  assign btn_sync   = btn_ff[SYNC_STAGES-1];
  assign release_ok = lock_sync & ~btn_stable;

  // NOTE: every register below uses non-blocking assignment so all flops sample pre-edge values,
  // which is what makes the synchroniser chains shift instead of collapsing into one stage.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lock_ff <= '0;
      btn_ff  <= '0;
    end else begin
      lock_ff <= {lock_ff[SYNC_STAGES-2:0], pll_locked};
      btn_ff  <= {btn_ff[SYNC_STAGES-2:0], btn_reset};
    end
  end

  // A new button level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync == btn_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_stable <= btn_sync;
      db_cnt     <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_LOCK;
      hold_cnt    <= '0;
      soc_reset_n <= 1'b0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (release_ok) begin
            state    <= STRETCH;
            hold_cnt <= '0;
          end
        end
        STRETCH: begin
          if (!release_ok) begin
            state <= WAIT_LOCK;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= RUN;
            soc_reset_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!release_ok) begin
            state       <= WAIT_LOCK;
            soc_reset_n <= 1'b0;
          end
        end
        default: begin
          state       <= WAIT_LOCK;
          soc_reset_n <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESET_CAUSE_EN
  logic       leaving;
  logic [1:0] cause_set;

  assign leaving   = (state != WAIT_LOCK) && !release_ok;
  assign cause_set = leaving ? {btn_stable, ~lock_sync} : 2'b00;

  // Set takes priority over a simultaneous clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cause <= 2'b00;
    end else begin
      cause <= (cause_clr ? 2'b00 : cause) | cause_set;
    end
  end
`endif

endmodule

// File: tb/tb_didactic_reset_ctrl.sv
// Self-checking bench for didactic_reset_ctrl: table-driven power-up, directed corner sequences and
// randomized stimulus against a sample-history reference model. Cause checks need RESET_CAUSE_EN.
module tb_didactic_reset_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int HOLD = 4;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       btn_reset;
  logic       cause_clr;
  logic       soc_reset_n;
  logic       lock_sync;
  logic       btn_stable;
`ifdef RESET_CAUSE_EN
  logic [1:0] cause;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  didactic_reset_ctrl #(
    .SYNC_STAGES(SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .pll_locked(pll_locked),
    .btn_reset(btn_reset),
`ifdef RESET_CAUSE_EN
    .cause_clr(cause_clr),
    .cause(cause),
`endif
    .soc_reset_n(soc_reset_n),
    .lock_sync(lock_sync),
    .btn_stable(btn_stable)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Holds reset for a few cycles, then releases it mid-cycle so the next rising edge is edge 1.
  task automatic apply_reset(input logic pll);
    reset      = 1'b0;
    pll_locked = pll;
    btn_reset  = 1'b0;
    cause_clr  = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic wait_for_soc(input logic val, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (soc_reset_n === val) begin
        n = i;
        break;
      end
    end
  endtask

  // Reference model, expressed as histories of samples rather than as a state machine:
  //  - lock/button synchronisers are a delay line of SYNC samples;
  //  - btn_stable flips when the last DEB synced samples all disagree with it;
  //  - soc_reset_n is 1 when the release condition has held for HOLD+1 consecutive samples;
  //  - a cause is recorded when the release condition drops after having held.
  bit         pll_q[$];
  bit         btn_q[$];
  bit         bs_hist[$];
  bit         m_lock, m_bs, m_stable, m_soc, m_ok_prev2;
  int         okrun;
  logic [1:0] m_cause;

  task automatic model_reset();
    pll_q.delete();
    btn_q.delete();
    bs_hist.delete();
    for (int i = 0; i < SYNC - 1; i++) begin
      pll_q.push_back(1'b0);
      btn_q.push_back(1'b0);
    end
    m_lock = 0; m_bs = 0; m_stable = 0; m_soc = 0; m_ok_prev2 = 0;
    okrun = 0;
    m_cause = 2'b00;
  endtask

  task automatic model_edge(input bit pll_in, input bit btn_in, input bit clr_in);
    bit         ok_prev;
    bit         all_differ;
    logic [1:0] set_bits;
    ok_prev  = m_lock && !m_stable;
    set_bits = (m_ok_prev2 && !ok_prev) ? {m_stable, !m_lock} : 2'b00;
    m_cause  = (clr_in ? 2'b00 : m_cause) | set_bits;
    m_soc    = (okrun >= HOLD + 1);
    bs_hist.push_back(m_bs);
    if (bs_hist.size() > DEB) void'(bs_hist.pop_front());
    all_differ = (bs_hist.size() == DEB);
    foreach (bs_hist[i]) if (bs_hist[i] == m_stable) all_differ = 0;
    if (all_differ) m_stable = !m_stable;
    pll_q.push_back(pll_in);
    btn_q.push_back(btn_in);
    m_lock     = pll_q.pop_front();
    m_bs       = btn_q.pop_front();
    m_ok_prev2 = ok_prev;
    okrun      = (m_lock && !m_stable) ? okrun + 1 : 0;
  endtask

  typedef struct {
    logic pll;
    logic btn;
    logic exp_soc;
    logic exp_lock;
    logic exp_stable;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t pu[10];
    int   n, stable_edge, fall_edge;
    bit   seen_stable, seen_low, rose;
    bit   r_pll, r_btn, r_clr;

    // Power-up, one row per edge after reset release.
    pu = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0}
    };

    reset      = 1'b0;
    pll_locked = 1'b1;
    btn_reset  = 1'b0;
    cause_clr  = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_soc", soc_reset_n, 0);
    check("reset_lock", lock_sync, 0);
    check("reset_stable", btn_stable, 0);
`ifdef RESET_CAUSE_EN
    check("reset_cause", cause, 0);
`endif
    @(negedge clk_in);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pll_locked = pu[i].pll;
      btn_reset  = pu[i].btn;
      tick();
      check($sformatf("pu_soc_e%0d", i + 1), soc_reset_n, pu[i].exp_soc);
      check($sformatf("pu_lock_e%0d", i + 1), lock_sync, pu[i].exp_lock);
      check($sformatf("pu_stable_e%0d", i + 1), btn_stable, pu[i].exp_stable);
    end

    // Bounce rejection while running.
    seen_stable = 0;
    seen_low    = 0;
    for (int i = 0; i < 24; i++) begin
      btn_reset = (i < 5) || (i >= 7 && i < 12);
      tick();
      if (btn_stable) seen_stable = 1;
      if (!soc_reset_n) seen_low = 1;
    end
    check("bounce_stable", seen_stable, 0);
    check("bounce_soc_low", seen_low, 0);

    // Valid press: held for 20 cycles, then released.
    stable_edge = -1;
    fall_edge   = -1;
    btn_reset   = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (stable_edge < 0 && btn_stable) stable_edge = i;
      if (fall_edge < 0 && !soc_reset_n) fall_edge = i;
    end
    check("press_stable_edge", stable_edge, 10);
    check("press_soc_fall_edge", fall_edge, 11);
`ifdef RESET_CAUSE_EN
    check("press_cause", cause, 2'b10);
`endif
    btn_reset = 1'b0;
    wait_for_soc(1'b1, 40, n);
    check("press_release_edge", n, 15);

    // Late lock.
    apply_reset(1'b0);
    repeat (50) tick();
    check("late_soc_before_lock", soc_reset_n, 0);
    pll_locked = 1'b1;
    wait_for_soc(1'b1, 30, n);
    check("late_lock_latency", n, 7);

    // Lock loss seen while the stretch counter is at 2.
    apply_reset(1'b1);
    repeat (3) tick();
    pll_locked = 1'b0;
    rose = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (soc_reset_n) rose = 1;
    end
    check("stretch_loss_no_rise", rose, 0);
    check("stretch_loss_lock", lock_sync, 0);
    pll_locked = 1'b1;
    wait_for_soc(1'b1, 30, n);
    check("stretch_relock_latency", n, 7);

`ifdef RESET_CAUSE_EN
    apply_reset(1'b1);
    repeat (10) tick();
    check("cause_run_soc", soc_reset_n, 1);
    check("cause_initial", cause, 2'b00);
    pll_locked = 1'b0;
    repeat (5) tick();
    check("cause_lock_loss", cause, 2'b01);
    pll_locked = 1'b1;
    repeat (10) tick();
    check("cause_relock_soc", soc_reset_n, 1);
    btn_reset = 1'b1;
    repeat (20) tick();
    btn_reset = 1'b0;
    repeat (20) tick();
    check("cause_both", cause, 2'b11);
    check("cause_rerun_soc", soc_reset_n, 1);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("cause_cleared", cause, 2'b00);
    pll_locked = 1'b0;
    repeat (2) tick();
    check("cause_clr_race_soc_before", soc_reset_n, 1);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    check("cause_clr_race_soc_after", soc_reset_n, 0);
    check("cause_set_wins", cause, 2'b01);
    pll_locked = 1'b1;
    repeat (10) tick();
`endif

    // Asynchronous reset while running.
    check("async_pre_soc", soc_reset_n, 1);
    @(posedge clk_in);
    #2;
    reset = 1'b0;
    #1;
    check("async_soc", soc_reset_n, 0);
    check("async_lock", lock_sync, 0);
`ifdef RESET_CAUSE_EN
    check("async_cause", cause, 2'b00);
`endif

    // Randomized stimulus against the reference model.
    apply_reset(1'b1);
    model_reset();
    r_pll = 1;
    r_btn = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(59) == 0) r_pll = !r_pll;
      if ($urandom_range(11) == 0) r_btn = !r_btn;
`ifdef RESET_CAUSE_EN
      r_clr = ($urandom_range(24) == 0);
`else
      r_clr = 0;
`endif
      pll_locked = r_pll;
      btn_reset  = r_btn;
      cause_clr  = r_clr;
      tick();
      model_edge(r_pll, r_btn, r_clr);
      check("rnd_soc", soc_reset_n, m_soc);
      check("rnd_lock", lock_sync, m_lock);
      check("rnd_stable", btn_stable, m_stable);
`ifdef RESET_CAUSE_EN
      check("rnd_cause", cause, m_cause);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
